// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, grant encoding and
// the width and saturating-increment helper for the optional statistics.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DBG  = 2'd2
    } arb_grant_t;

    localparam int STAT_W = 16;

    // Statistics stick at all-ones rather than wrapping to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating up-counter with synchronous clear; tc flags that the count has
// reached LIMIT, and the count then holds there until cleared.
module arb_wait_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    logic [WIDTH-1:0] count;

    assign tc = (count == WIDTH'(LIMIT));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (fixed priority) and the
// debug/loader port, forcing one dbg grant after MAX_WAIT blocked cycles.
// Optional grant statistics are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_func3,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_valid,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [2:0]        dbg_func3,
    output logic              dbg_ready,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [STAT_W-1:0] stat_cpu_grants,
    output logic [STAT_W-1:0] stat_dbg_grants,
    output logic [STAT_W-1:0] stat_forced
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_FORCE = FORCE;

    logic [1:0] state;
    logic [1:0] state_next;
    arb_grant_t grant;
    logic       cpu_req;
    logic       dbg_blocked;
    logic       dbg_read_hs;
    logic       cnt_clear;
    logic       cnt_inc;
    logic       cnt_tc;

    assign cpu_req     = cpu_rd | cpu_wr;
    assign dbg_blocked = dbg_valid & ~dbg_ready;
    assign dbg_read_hs = dbg_valid & dbg_ready & ~dbg_we;

    // A forced cycle overrides cpu priority; otherwise cpu wins any contention.
    always_comb begin
        grant     = GNT_NONE;
        cpu_stall = 1'b0;
        dbg_ready = 1'b0;
        if (state == ST_FORCE) begin
            grant     = GNT_DBG;
            cpu_stall = cpu_req;
            dbg_ready = 1'b1;
        end else if (cpu_req) begin
            grant = GNT_CPU;
        end else if (dbg_valid) begin
            grant     = GNT_DBG;
            dbg_ready = 1'b1;
        end
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_func3 = '0;
        cpu_rdata = '0;
        case (grant)
            GNT_CPU: begin
                mem_rd    = cpu_rd & ~cpu_wr;
                mem_wr    = cpu_wr;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_func3 = cpu_func3;
                cpu_rdata = mem_rdata;
            end
            GNT_DBG: begin
                mem_rd    = dbg_valid & ~dbg_we;
                mem_wr    = dbg_valid & dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                mem_func3 = dbg_func3;
            end
            default: ;
        endcase
    end

    // The counter holds the number of consecutive blocked cycles seen so far.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dbg_blocked) begin
                    state_next = ST_WAIT;
                    cnt_inc    = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dbg_blocked) begin
                    if (cnt_tc) begin
                        state_next = ST_FORCE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else begin
                    state_next = ST_IDLE;
                    cnt_clear  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    arb_wait_counter #(
        .WIDTH (CNT_W),
        .LIMIT (MAX_WAIT - 1)
    ) u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    // Read data returns one cycle after the dbg read handshake and then holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            dbg_rvalid <= dbg_read_hs;
            if (dbg_read_hs) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] cpu_grant_cnt;
    logic [STAT_W-1:0] dbg_grant_cnt;
    logic [STAT_W-1:0] forced_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_grant_cnt <= '0;
            dbg_grant_cnt <= '0;
            forced_cnt    <= '0;
        end else begin
            if (grant == GNT_CPU) begin
                cpu_grant_cnt <= sat_inc(cpu_grant_cnt);
            end
            if (grant == GNT_DBG) begin
                dbg_grant_cnt <= sat_inc(dbg_grant_cnt);
            end
            if (state == ST_FORCE) begin
                forced_cnt <= sat_inc(forced_cnt);
            end
        end
    end

    assign stat_cpu_grants = cpu_grant_cnt;
    assign stat_dbg_grants = dbg_grant_cnt;
    assign stat_forced     = forced_cnt;
`else
    assign stat_cpu_grants = '0;
    assign stat_dbg_grants = '0;
    assign stat_forced     = '0;
`endif

endmodule
